pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Program-counter register and instruction-fetch sequencer.
- Consumes the next-PC value produced by Branch_MUX, together with the branch/jump redirect strobe.
- Issues requests to instruction memory and presents the fetched instruction to the IF/ID boundary.
- Holds fetched data across decode stalls using a one-entry skid buffer, and flushes in-flight work on redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, sequential PC increment in bytes.

Ports:
- clk  in  1  Single clock; all state updates on posedge.
- rst_n  in  1  Synchronous, active-low reset, sampled on posedge clk.
- in_next_pc  in  32  Redirect target from Branch_MUX Out.
- in_redirect  in  1  Branch taken or jump. Load in_next_pc and flush; one-cycle pulse.
- in_stall  in  1  Decode cannot accept; out_* must hold.
- imem_req  out  1  Fetch request valid.
- imem_addr  out  32  Fetch address; equals pc register.
- imem_ready  in  1  Memory accepts request and returns imem_rdata this cycle.
- imem_rdata  in  32  Instruction word; valid when imem_req && imem_ready.
- out_valid  out  1  out_instr, out_pc and out_pc_plus4 are valid.
- out_instr  out  32  Fetched instruction.
- out_pc  out  32  Address of out_instr.
- out_pc_plus4  out  32  out_pc + PC_STEP, mod 2^32; feeds the upstream PC+Imm adder.

Behaviour:
- Reset (rst_n=0 at posedge):
  - pc=RESET_PC; state=IDLE.
  - out_valid=0; out_instr=0; out_pc=0; out_pc_plus4=0.
  - skid_valid=0; pend_valid=0; imem_req=0.
  - Reset mid-transfer abandons the transfer; no response is captured.
- States and imem_req:
  - IDLE (req=0) -> FETCH after one cycle.
  - FETCH (req=1, addr=pc).
  - HOLD (req=0).
- Handshake: while imem_req=1 without imem_ready, imem_addr stays stable. A transfer completes on any cycle with req && ready.
- FETCH, transfer completes, no redirect, pend_valid=0:
  - pc <= pc+PC_STEP (wraps at 2^32).
  - If !out_valid || !in_stall: load out_* with {rdata, pc, pc+4}; out_valid<=1.
  - Else: load skid with the same data; skid_valid<=1; go to HOLD.
- FETCH, no transfer: if out_valid && !in_stall, then out_valid<=0 (the instruction was consumed).
- HOLD:
  - When in_stall=0: out_* <= skid; skid_valid<=0; go to FETCH.
  - Otherwise stay in HOLD.
- Redirect (in_redirect=1) has priority over stall and sequential fetch. In every case out_valid<=0 and skid_valid<=0 on the same edge.
  - FETCH with transfer completing this cycle: discard rdata; pc<=in_next_pc; stay in FETCH.
  - FETCH with request outstanding (no ready): pend_pc<=in_next_pc; pend_valid<=1. pc is unchanged, keeping the address stable.
  - HOLD or IDLE: pc<=in_next_pc; go to FETCH (IDLE still spends its one cycle).
- Transfer completes while pend_valid=1 and no new redirect:
  - Discard rdata; pc<=pend_pc; pend_valid<=0.
  - out_valid stays 0.
- Redirect while pend_valid=1 and no ready: pend_pc overwritten, so the newest target wins.
- Redirect coincident with a completing transfer while pend_valid=1: pc<=in_next_pc; pend_valid<=0.
- Latency: out_valid rises one cycle after the completing transfer. Redirect-to-first-request is 1 cycle with no outstanding request; otherwise it waits for the outstanding transfer.
- in_stall with out_valid=0 does not block loading out_*.

Decomposition:
- Shared cpu package:
  - Fetch state enum {IDLE, FETCH, HOLD}.
  - XLEN=32.
  - RESET_PC default.
  - NOP encoding 32'h0 (used for out_instr reset).
- No sub-module required. The skid register may be a small fetch_skid_buf, but is kept inline by default.

Test Plan:
- Reset then free-running fetch, ready=1 always, stall=0:
  - imem_addr sequence 0,4,8,12.
  - out_pc follows 1 cycle behind; out_pc_plus4 = out_pc+4.
- Stall: raise in_stall for 3 cycles while out_valid=1 at out_pc=8.
  - out_* hold at 8; the address-12 response goes to the skid; imem_req=0 in HOLD.
  - After the stall drops: out_pc=12, then 16 continues with no loss or duplicate.
- Redirect with imem_ready low: redirect to 32'h100 while the request at 0x10 is outstanding.
  - imem_addr holds 0x10 until ready.
  - The 0x10 data is discarded (out_valid=0); the next request addr=0x100.
- Redirect coincident with ready: redirect to 0x200 on a completing transfer.
  - Response dropped; next addr=0x200; out_valid=0 for that cycle.
- Wrap and reset: with RESET_PC=32'hFFFF_FFFC, fetch two words → addrs FFFF_FFFC, 0000_0000.
- Reset mid-stall: assert rst_n=0 mid-stall → all outputs return to reset values on the next edge; skid is cleared.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
// Shared fetch-side types and constants for the pc_fetch_unit slice.
package pc_fetch_unit_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StHold
    } fetch_state_e;

endpackage

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch sequencer with a one-entry skid buffer
// and deferred redirect while a memory request is outstanding.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned     PC_STEP  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] in_next_pc,
    input  logic            in_redirect,
    input  logic            in_stall,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            out_valid,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_pc_plus4
);

    fetch_state_e    state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pend_pc_q;
    logic            pend_valid_q;
    logic            out_valid_q;
    logic [XLEN-1:0] out_instr_q;
    logic [XLEN-1:0] out_pc_q;
    logic [XLEN-1:0] out_pc_plus4_q;
    logic            skid_valid_q;
    logic [XLEN-1:0] skid_instr_q;
    logic [XLEN-1:0] skid_pc_q;
    logic [XLEN-1:0] skid_pc_plus4_q;

    logic            xfer;
    logic [XLEN-1:0] pc_next_seq;

    assign imem_req     = (state_q == StFetch);
    assign imem_addr    = pc_q;
    assign xfer         = imem_req && imem_ready;
    assign pc_next_seq  = pc_q + XLEN'(PC_STEP);

    assign out_valid    = out_valid_q;
    assign out_instr    = out_instr_q;
    assign out_pc       = out_pc_q;
    assign out_pc_plus4 = out_pc_plus4_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= StIdle;
            pc_q            <= RESET_PC;
            pend_pc_q       <= '0;
            pend_valid_q    <= 1'b0;
            out_valid_q     <= 1'b0;
            out_instr_q     <= NOP_INSTR;
            out_pc_q        <= '0;
            out_pc_plus4_q  <= '0;
            skid_valid_q    <= 1'b0;
            skid_instr_q    <= NOP_INSTR;
            skid_pc_q       <= '0;
            skid_pc_plus4_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_q <= StFetch;
                    if (in_redirect) begin
                        pc_q         <= in_next_pc;
                        out_valid_q  <= 1'b0;
                        skid_valid_q <= 1'b0;
                    end
                end
                StFetch: begin
                    if (in_redirect) begin
                        out_valid_q  <= 1'b0;
                        skid_valid_q <= 1'b0;
                        if (xfer) begin
                            pc_q         <= in_next_pc;
                            pend_valid_q <= 1'b0;
                        end else begin
                            // Address must stay stable; remember the target instead.
                            pend_pc_q    <= in_next_pc;
                            pend_valid_q <= 1'b1;
                        end
                    end else if (xfer) begin
                        if (pend_valid_q) begin
                            // Response belongs to the squashed path.
                            pc_q         <= pend_pc_q;
                            pend_valid_q <= 1'b0;
                            out_valid_q  <= 1'b0;
                        end else begin
                            pc_q <= pc_next_seq;
                            if (!out_valid_q || !in_stall) begin
                                out_valid_q    <= 1'b1;
                                out_instr_q    <= imem_rdata;
                                out_pc_q       <= pc_q;
                                out_pc_plus4_q <= pc_next_seq;
                            end else begin
                                skid_valid_q    <= 1'b1;
                                skid_instr_q    <= imem_rdata;
                                skid_pc_q       <= pc_q;
                                skid_pc_plus4_q <= pc_next_seq;
                                state_q         <= StHold;
                            end
                        end
                    end else if (out_valid_q && !in_stall) begin
                        out_valid_q <= 1'b0;
                    end
                end
                StHold: begin
                    if (in_redirect) begin
                        pc_q         <= in_next_pc;
                        out_valid_q  <= 1'b0;
                        skid_valid_q <= 1'b0;
                        state_q      <= StFetch;
                    end else if (!in_stall) begin
                        out_valid_q    <= skid_valid_q;
                        out_instr_q    <= skid_instr_q;
                        out_pc_q       <= skid_pc_q;
                        out_pc_plus4_q <= skid_pc_plus4_q;
                        skid_valid_q   <= 1'b0;
                        state_q        <= StFetch;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit; memory returns addr + 0x1000_0000.
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] in_next_pc;
    logic        in_redirect;
    logic        in_stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;

    logic        w_rst_n;
    logic        w_imem_req;
    logic [31:0] w_imem_addr;
    logic [31:0] w_imem_rdata;
    logic        w_out_valid;
    logic [31:0] w_out_instr;
    logic [31:0] w_out_pc;
    logic [31:0] w_out_pc_plus4;
    logic        w_one;
    logic        w_zero;
    logic [31:0] w_zero_pc;

    int total;
    int bad;

    assign imem_rdata   = imem_addr + 32'h1000_0000;
    assign w_imem_rdata = w_imem_addr + 32'h1000_0000;
    assign w_one        = 1'b1;
    assign w_zero       = 1'b0;
    assign w_zero_pc    = 32'h0;

    pc_fetch_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_next_pc   (in_next_pc),
        .in_redirect  (in_redirect),
        .in_stall     (in_stall),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .out_valid    (out_valid),
        .out_instr    (out_instr),
        .out_pc       (out_pc),
        .out_pc_plus4 (out_pc_plus4)
    );

    pc_fetch_unit #(
        .RESET_PC (32'hFFFF_FFFC),
        .PC_STEP  (4)
    ) dut_wrap (
        .clk          (clk),
        .rst_n        (w_rst_n),
        .in_next_pc   (w_zero_pc),
        .in_redirect  (w_zero),
        .in_stall     (w_zero),
        .imem_req     (w_imem_req),
        .imem_addr    (w_imem_addr),
        .imem_ready   (w_one),
        .imem_rdata   (w_imem_rdata),
        .out_valid    (w_out_valid),
        .out_instr    (w_out_instr),
        .out_pc       (w_out_pc),
        .out_pc_plus4 (w_out_pc_plus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n       = 1'b0;
        in_redirect = 1'b0;
        in_stall    = 1'b0;
        imem_ready  = 1'b1;
        in_next_pc  = 32'h0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        do_reset();
        total++;
        if (out_valid !== 1'b0 || imem_req !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctl: valid=%b req=%b, required 0 0", out_valid, imem_req);
        end
        total++;
        if (out_instr !== 32'h0 || out_pc !== 32'h0 || out_pc_plus4 !== 32'h0) begin
            bad++;
            $display("FAIL reset_out: instr=%h pc=%h pc4=%h, required 0 0 0",
                     out_instr, out_pc, out_pc_plus4);
        end
        total++;
        if (imem_addr !== 32'h0) begin
            bad++;
            $display("FAIL reset_addr: addr=%h, required 00000000", imem_addr);
        end
    endtask

    task automatic test_free_run;
        logic [31:0] exp_addr [4];
        exp_addr[0] = 32'h0;
        exp_addr[1] = 32'h4;
        exp_addr[2] = 32'h8;
        exp_addr[3] = 32'hC;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (imem_req !== 1'b1 || imem_addr !== exp_addr[i]) begin
                bad++;
                $display("FAIL run_addr[%0d]: req=%b addr=%h, required 1 %h",
                         i, imem_req, imem_addr, exp_addr[i]);
            end
            if (i == 0) begin
                total++;
                if (out_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL run_first_valid: valid=%b, required 0", out_valid);
                end
            end else begin
                total++;
                if (out_valid !== 1'b1 || out_pc !== exp_addr[i-1] ||
                    out_pc_plus4 !== exp_addr[i] ||
                    out_instr !== exp_addr[i-1] + 32'h1000_0000) begin
                    bad++;
                    $display("FAIL run_out[%0d]: v=%b pc=%h pc4=%h instr=%h, required 1 %h %h %h",
                             i, out_valid, out_pc, out_pc_plus4, out_instr, exp_addr[i-1],
                             exp_addr[i], exp_addr[i-1] + 32'h1000_0000);
                end
            end
        end
    endtask

    task automatic test_stall;
        do_reset();
        for (int i = 0; i < 4; i++) step();
        in_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (out_valid !== 1'b1 || out_pc !== 32'h8 || out_instr !== 32'h1000_0008 ||
                imem_req !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold[%0d]: v=%b pc=%h instr=%h req=%b, required 1 8 10000008 0",
                         i, out_valid, out_pc, out_instr, imem_req);
            end
        end
        in_stall = 1'b0;
        step();
        total++;
        if (out_valid !== 1'b1 || out_pc !== 32'hC || out_instr !== 32'h1000_000C ||
            out_pc_plus4 !== 32'h10) begin
            bad++;
            $display("FAIL stall_skid: v=%b pc=%h instr=%h pc4=%h, required 1 c 1000000c 10",
                     out_valid, out_pc, out_instr, out_pc_plus4);
        end
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
            bad++;
            $display("FAIL stall_resume_addr: req=%b addr=%h, required 1 10", imem_req, imem_addr);
        end
        step();
        total++;
        if (out_valid !== 1'b1 || out_pc !== 32'h10 || out_instr !== 32'h1000_0010) begin
            bad++;
            $display("FAIL stall_next: v=%b pc=%h instr=%h, required 1 10 10000010",
                     out_valid, out_pc, out_instr);
        end
    endtask

    task automatic test_redirect_pending;
        do_reset();
        for (int i = 0; i < 5; i++) step();
        total++;
        if (imem_addr !== 32'h10) begin
            bad++;
            $display("FAIL redir_setup: addr=%h, required 10", imem_addr);
        end
        imem_ready  = 1'b0;
        in_redirect = 1'b1;
        in_next_pc  = 32'h100;
        step();
        in_redirect = 1'b0;
        total++;
        if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h10) begin
            bad++;
            $display("FAIL redir_wait0: v=%b req=%b addr=%h, required 0 1 10",
                     out_valid, imem_req, imem_addr);
        end
        step();
        total++;
        if (imem_addr !== 32'h10) begin
            bad++;
            $display("FAIL redir_wait1: addr=%h, required 10", imem_addr);
        end
        imem_ready = 1'b1;
        step();
        total++;
        if (out_valid !== 1'b0 || imem_addr !== 32'h100) begin
            bad++;
            $display("FAIL redir_drop: v=%b addr=%h, required 0 100", out_valid, imem_addr);
        end
        step();
        total++;
        if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_instr !== 32'h1000_0100) begin
            bad++;
            $display("FAIL redir_target: v=%b pc=%h instr=%h, required 1 100 10000100",
                     out_valid, out_pc, out_instr);
        end
    endtask

    task automatic test_redirect_xfer;
        total++;
        if (imem_addr !== 32'h104) begin
            bad++;
            $display("FAIL rx_setup: addr=%h, required 104", imem_addr);
        end
        in_redirect = 1'b1;
        in_next_pc  = 32'h200;
        step();
        in_redirect = 1'b0;
        total++;
        if (out_valid !== 1'b0 || imem_addr !== 32'h200 || imem_req !== 1'b1) begin
            bad++;
            $display("FAIL rx_drop: v=%b addr=%h req=%b, required 0 200 1",
                     out_valid, imem_addr, imem_req);
        end
        step();
        total++;
        if (out_valid !== 1'b1 || out_pc !== 32'h200 || out_pc_plus4 !== 32'h204) begin
            bad++;
            $display("FAIL rx_target: v=%b pc=%h pc4=%h, required 1 200 204",
                     out_valid, out_pc, out_pc_plus4);
        end
    endtask

    task automatic test_wrap;
        w_rst_n = 1'b0;
        step();
        step();
        w_rst_n = 1'b1;
        total++;
        if (w_imem_req !== 1'b0 || w_imem_addr !== 32'hFFFF_FFFC) begin
            bad++;
            $display("FAIL wrap_reset: req=%b addr=%h, required 0 fffffffc", w_imem_req, w_imem_addr);
        end
        step();
        total++;
        if (w_imem_req !== 1'b1 || w_imem_addr !== 32'hFFFF_FFFC) begin
            bad++;
            $display("FAIL wrap_addr0: req=%b addr=%h, required 1 fffffffc", w_imem_req, w_imem_addr);
        end
        step();
        total++;
        if (w_imem_addr !== 32'h0 || w_out_valid !== 1'b1 || w_out_pc !== 32'hFFFF_FFFC ||
            w_out_pc_plus4 !== 32'h0 || w_out_instr !== 32'h0FFF_FFFC) begin
            bad++;
            $display("FAIL wrap_out0: addr=%h v=%b pc=%h pc4=%h instr=%h, required 0 1 fffffffc 0 0ffffffc",
                     w_imem_addr, w_out_valid, w_out_pc, w_out_pc_plus4, w_out_instr);
        end
        step();
        total++;
        if (w_out_pc !== 32'h0 || w_out_pc_plus4 !== 32'h4 || w_imem_addr !== 32'h4) begin
            bad++;
            $display("FAIL wrap_out1: pc=%h pc4=%h addr=%h, required 0 4 4",
                     w_out_pc, w_out_pc_plus4, w_imem_addr);
        end
    endtask

    task automatic test_reset_mid_stall;
        do_reset();
        for (int i = 0; i < 4; i++) step();
        in_stall = 1'b1;
        step();
        step();
        rst_n = 1'b0;
        step();
        total++;
        if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_pc !== 32'h0 ||
            out_pc_plus4 !== 32'h0 || imem_req !== 1'b0 || imem_addr !== 32'h0) begin
            bad++;
            $display("FAIL rst_stall: v=%b instr=%h pc=%h pc4=%h req=%b addr=%h, required all 0",
                     out_valid, out_instr, out_pc, out_pc_plus4, imem_req, imem_addr);
        end
        rst_n    = 1'b1;
        in_stall = 1'b0;
        step();
        total++;
        if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            bad++;
            $display("FAIL rst_restart: v=%b req=%b addr=%h, required 0 1 0",
                     out_valid, imem_req, imem_addr);
        end
        step();
        total++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h1000_0000) begin
            bad++;
            $display("FAIL rst_first: v=%b pc=%h instr=%h, required 1 0 10000000",
                     out_valid, out_pc, out_instr);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        total       = 0;
        bad         = 0;
        rst_n       = 1'b0;
        w_rst_n     = 1'b0;
        in_redirect = 1'b0;
        in_stall    = 1'b0;
        imem_ready  = 1'b1;
        in_next_pc  = 32'h0;
        test_reset();
        test_free_run();
        test_stall();
        test_redirect_pending();
        test_redirect_xfer();
        test_wrap();
        test_reset_mid_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
